// File: rtl/io_input_conditioner.sv
// Synchronizes, debounces and polarity-normalizes board switches and buttons ahead of the core.
// Define IOCOND_PRESS_LATCH_EN to build the sticky per-button press flags.
module io_input_conditioner #(
  parameter int SW_W           = 32,
  parameter int BTN_W          = 4,
  parameter int TICK_CYCLES    = 100000,
  parameter int STABLE_TICKS   = 10,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_sw_raw,
  input  logic [BTN_W-1:0] i_btn_raw,
  input  logic [BTN_W-1:0] i_btn_clr,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_io_btn,
  output logic [BTN_W-1:0] o_btn_press,
  output logic             o_tick
);

  localparam int N  = SW_W + BTN_W;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [BTN_W-1:0] BTN_IDLE  = (BTN_ACTIVE_LOW != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [SW_W-1:0]  sw_meta_reg, sw_sync_reg;
  logic [BTN_W-1:0] btn_meta_reg, btn_sync_reg;
  logic [N-1:0]     s_vec;
  logic [N-1:0]     q_vec;
  logic [TW-1:0]    tick_cnt_reg;
  logic             tick;

  // Button flops reset to the released pin level so no false press is seen leaving reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= BTN_IDLE;
      btn_sync_reg <= BTN_IDLE;
    end else begin
      sw_meta_reg  <= i_sw_raw;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= i_btn_raw;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  assign s_vec = {(BTN_ACTIVE_LOW != 0) ? ~btn_sync_reg : btn_sync_reg, sw_sync_reg};

  assign tick = (tick_cnt_reg == TICK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  // A new level is accepted only after STABLE_TICKS consecutive differing samples.
  for (genvar gi = 0; gi < N; gi++) begin : g_deb
    logic [CW-1:0] cnt_reg;
    logic          q_reg;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        cnt_reg <= '0;
        q_reg   <= 1'b0;
      end else if (tick) begin
        if (s_vec[gi] == q_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          q_reg   <= s_vec[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign q_vec[gi] = q_reg;
  end

  assign o_io_sw  = q_vec[SW_W-1:0];
  assign o_io_btn = q_vec[N-1:SW_W];
  assign o_tick   = tick;

`ifdef IOCOND_PRESS_LATCH_EN
  logic [BTN_W-1:0] btn_prev_reg;
  logic [BTN_W-1:0] press_reg;

  // Set has priority over clear so a press coinciding with a clear is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_prev_reg <= '0;
      press_reg    <= '0;
    end else begin
      btn_prev_reg <= o_io_btn;
      press_reg    <= (press_reg & ~i_btn_clr) | (o_io_btn & ~btn_prev_reg);
    end
  end

  assign o_btn_press = press_reg;
`else
  logic unused_btn_clr;

  assign unused_btn_clr = ^i_btn_clr;
  assign o_btn_press    = '0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with a queue-based scoreboard of expected values.
// Press-flag expectations follow IOCOND_PRESS_LATCH_EN.
module tb_io_input_conditioner;

`ifdef IOCOND_PRESS_LATCH_EN
  localparam bit PRESS_EN = 1'b1;
`else
  localparam bit PRESS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [3:0]  btn_clr;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_press;
  logic        tick;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  io_input_conditioner #(
    .SW_W(32), .BTN_W(4), .TICK_CYCLES(4), .STABLE_TICKS(3), .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw), .i_btn_clr(btn_clr),
    .o_io_sw(io_sw), .o_io_btn(io_btn), .o_btn_press(btn_press), .o_tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    e = exp_q.pop_front();
    total_cnt++;
    assert (obs === e.val) begin
      pass_cnt++;
      $display("check %s observed=%0h", e.tag, obs);
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    push_exp(tag, exp);
    pop_chk(obs);
  endtask

  // Bounded wait for a tick cycle; leaves the bench inside that cycle.
  task automatic tick_align();
    for (int i = 0; i < 8 && tick !== 1'b1; i++) step();
    chk("tick_align", 64'(tick), 64'd1);
  endtask

  initial begin
    rst     = 1'b1;
    sw_raw  = 32'hFFFF_FFFF;
    btn_raw = 4'hF;
    btn_clr = 4'h0;

    // Reset held for three edges: every output reads zero.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outs", {io_sw, io_btn, btn_press, tick}, 64'd0);
    end
    rst    = 1'b0;
    sw_raw = 32'h0;

    // First tick lands in the 4th cycle after release.
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("first_tick_c%0d", k), 64'(tick), (k == 4) ? 64'd1 : 64'd0);
      if (k < 4) step();
    end

    // Clean switch step driven in a tick cycle: 12 edges still old, 13th edge new.
    tick_align();
    sw_raw = 32'h0000_00A5;
    push_exp("sw_before_edge12", 64'h0);
    push_exp("sw_after_edge13", 64'hA5);
    for (int k = 1; k <= 12; k++) step();
    pop_chk(64'(io_sw));
    step();
    pop_chk(64'(io_sw));
    push_exp("sw_held", 64'hA5);
    for (int k = 0; k < 20; k++) step();
    pop_chk(64'(io_sw));

    // Bounce on btn0: low for 2 samples, high for 1, then low; rises at edge 25.
    tick_align();
    btn_raw = 4'hE;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 24) chk("btn0_no_early_rise", 64'(io_btn), 64'h0);
      if (k == 25) chk("btn0_rise", 64'(io_btn), 64'h1);
      if (k < 24 && io_btn !== 4'h0) chk($sformatf("btn0_glitch_e%0d", k), 64'(io_btn), 64'h0);
      if (k == 9)  btn_raw = 4'hF;
      if (k == 13) btn_raw = 4'hE;
    end
    step();
    chk("btn0_press_set", 64'(btn_press), PRESS_EN ? 64'h1 : 64'h0);
    btn_raw = 4'hF;
    for (int k = 0; k < 16; k++) step();
    chk("btn0_released", 64'(io_btn), 64'h0);
    btn_clr = 4'b0001;
    step();
    btn_clr = 4'b0000;
    chk("btn0_press_cleared", 64'(btn_press), 64'h0);

    // Press flag on btn1: persists after release, clear takes effect next cycle.
    btn_raw = 4'hD;
    for (int k = 0; k < 16; k++) step();
    chk("btn1_pressed", 64'(io_btn), 64'h2);
    btn_raw = 4'hF;
    for (int k = 0; k < 16; k++) step();
    chk("btn1_released", 64'(io_btn), 64'h0);
    chk("btn1_press_sticky", 64'(btn_press), PRESS_EN ? 64'h2 : 64'h0);
    btn_clr = 4'b0010;
    step();
    btn_clr = 4'b0000;
    chk("btn1_press_cleared", 64'(btn_press), 64'h0);

    // Clear pulsed in the first cycle btn2's debounced level is high: set wins.
    tick_align();
    btn_raw = 4'hB;
    for (int k = 1; k <= 12; k++) step();
    chk("btn2_before_rise", 64'(io_btn), 64'h0);
    step();
    chk("btn2_rise", 64'(io_btn), 64'h4);
    btn_clr = 4'b0100;
    step();
    btn_clr = 4'b0000;
    chk("btn2_collision_set_wins", 64'(btn_press), PRESS_EN ? 64'h4 : 64'h0);
    step();
    chk("btn2_press_holds", 64'(btn_press), PRESS_EN ? 64'h4 : 64'h0);

    // Tick period is exactly four cycles across several wraps.
    tick_align();
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 4; k++) begin
        step();
        chk($sformatf("tick_period_p%0d_c%0d", p, k), 64'(tick), (k == 4) ? 64'd1 : 64'd0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
